// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one 4-bit ALU between two requesters.
// Optional completed-operation counter enabled by ALU_SHARE_CTRL_STATS_EN.
module alu_share_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [2:0] req0_op,
  input  logic [2:0] req1_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic [2:0] alu_s,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_y,
  input  logic [3:0] alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_y,
  output logic       rsp_flag,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_reg, state_next;
  logic       last_grant_reg;
  logic       issue_id_reg;
  logic [2:0] alu_s_reg;
  logic [3:0] alu_a_reg, alu_b_reg;
  logic       rsp_id_reg, rsp_flag_reg;
  logic [3:0] rsp_y_reg;

  logic       grant_any, grant_id, accept, rsp_fire;
  logic [2:0] grant_op;
  logic [3:0] grant_a, grant_b;

  // Only cout[0] carries information; the upper ALU bits are ignored.
  logic unused_cout;
  assign unused_cout = ^alu_cout[3:1];

  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
    grant_op  = grant_id ? req1_op : req0_op;
    grant_a   = grant_id ? req1_a  : req0_a;
    grant_b   = grant_id ? req1_b  : req0_b;
    accept    = (state_reg == IDLE) && grant_any;
    rsp_fire  = (state_reg == RESP) && rsp_ready;
  end

  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;
  assign rsp_valid  = (state_reg == RESP);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      issue_id_reg   <= 1'b0;
      alu_s_reg      <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      rsp_id_reg     <= 1'b0;
      rsp_y_reg      <= '0;
      rsp_flag_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        alu_s_reg      <= grant_op;
        alu_a_reg      <= grant_a;
        alu_b_reg      <= grant_b;
        issue_id_reg   <= grant_id;
        last_grant_reg <= grant_id;
      end
      // Logic ops (select MSB set) leave cout stale, so the flag is forced low.
      if (state_reg == EXEC) begin
        rsp_id_reg   <= issue_id_reg;
        rsp_y_reg    <= alu_y;
        rsp_flag_reg <= ~alu_s_reg[2] & alu_cout[0];
      end
    end
  end

  assign alu_s    = alu_s_reg;
  assign alu_a    = alu_a_reg;
  assign alu_b    = alu_b_reg;
  assign rsp_id   = rsp_id_reg;
  assign rsp_y    = rsp_y_reg;
  assign rsp_flag = rsp_flag_reg;

`ifdef ALU_SHARE_CTRL_STATS_EN
  logic [7:0] op_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_reg <= '0;
    end else if (rsp_fire && op_count_reg != 8'hff) begin
      op_count_reg <= op_count_reg + 8'd1;
    end
  end

  assign op_count = op_count_reg;
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
  assign op_count    = '0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: random and directed requests against
// an arithmetic reference model plus a behavioural ALU.
module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] alu_s;
  logic [3:0] alu_a, alu_b, alu_y, alu_cout;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [3:0] rsp_y;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flag(rsp_flag),
    .op_count(op_count)
  );

  // Behavioural ALU; cout upper bits and logic-op cout are junk on purpose.
  logic [3:0] junk;
  logic [4:0] alu_r;
  always_comb begin
    alu_r = '0;
    case (alu_s)
      3'd0: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_r = {1'b0, alu_a} + 5'd1;
      3'd3: alu_r = {1'b0, alu_a} - 5'd1;
      3'd4: alu_r = {1'b0, alu_a & alu_b};
      3'd5: alu_r = {1'b0, alu_a | alu_b};
      3'd6: alu_r = {1'b0, alu_a ^ alu_b};
      default: alu_r = {1'b0, ~alu_a};
    endcase
  end
  assign alu_y    = alu_r[3:0];
  assign alu_cout = alu_s[2] ? junk : {junk[3:1], alu_r[4]};

  typedef struct {
    logic       id;
    logic [3:0] y;
    logic       flag;
  } rsp_t;
  rsp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics: 4-bit result modulo 16, flag = bit 4 for arithmetic.
  function automatic rsp_t ref_op(input logic id, input logic [2:0] op,
                                  input logic [3:0] a4, input logic [3:0] b4);
    rsp_t r;
    int a, b, s;
    bit fl;
    a = int'(a4);
    b = int'(b4);
    fl = 1'b0;
    case (op)
      3'd0: begin s = a + b; fl = (s > 15); end
      3'd1: begin s = a - b; fl = (a < b);  end
      3'd2: begin s = a + 1; fl = (a == 15); end
      3'd3: begin s = a - 1; fl = (a == 0);  end
      3'd4: s = a & b;
      3'd5: s = a | b;
      3'd6: s = a ^ b;
      default: s = 15 - a;
    endcase
    r.id   = id;
    r.y    = 4'(s & 15);
    r.flag = fl;
    return r;
  endfunction

  // Model: at most one operation in flight, age counts cycles since acceptance.
  bit         m_busy, m_last, started;
  int         m_age, m_count, m_total;
  logic [2:0] m_s;
  logic [3:0] m_a, m_b;

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_age = 0; m_count = 0;
    m_s = '0; m_a = '0; m_b = '0;
    exp_q.delete();
  endtask

  task automatic cycle(input bit r,
                       input bit v0, input logic [2:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                       input bit v1, input logic [2:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                       input bit rr);
    bit g_any, g;
    rsp_t e;
    @(negedge clk);
    rst_n = r;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready = rr;
    junk = 4'($urandom);
    #1;
    g_any = v0 | v1;
    g = (v0 && v1) ? ~m_last : v1;
    chk("req0_ready", 32'(req0_ready), 32'(!m_busy && g_any && !g));
    chk("req1_ready", 32'(req1_ready), 32'(!m_busy && g_any && g));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
    chk("alu_s", 32'(alu_s), 32'(m_s));
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    chk("op_count", 32'(op_count), 32'(m_count));
    if (!r) begin
      model_reset();
    end else if (!m_busy && g_any) begin
      m_busy = 1; m_age = 1; m_last = g;
      m_s = g ? o1 : o0;
      m_a = g ? a1 : a0;
      m_b = g ? b1 : b0;
      e = ref_op(g, m_s, m_a, m_b);
      exp_q.push_back(e);
      $display("ISSUE id=%0d op=%0d a=%0d b=%0d -> y=%0d flag=%0d", g, m_s, m_a, m_b, e.y, e.flag);
    end else if (m_busy) begin
      if (m_age >= 2 && rr) begin
        m_busy = 0;
        m_total++;
`ifdef ALU_SHARE_CTRL_STATS_EN
        if (m_count < 255) m_count++;
`endif
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rcycle(input int rr_pct);
    cycle(1, ($urandom_range(0, 3) != 0), 3'($urandom), 4'($urandom), 4'($urandom),
             ($urandom_range(0, 3) != 0), 3'($urandom), 4'($urandom), 4'($urandom),
             ($urandom_range(0, 99) < rr_pct));
  endtask

  // Monitor: compares the presented response with the scoreboard head.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (started && rst_n && rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
        end else begin
          e = exp_q[0];
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_y", 32'(rsp_y), 32'(e.y));
          chk("rsp_flag", 32'(rsp_flag), 32'(e.flag));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            $display("RSP id=%0d y=%0d flag=%0d op_count=%0d", rsp_id, rsp_y, rsp_flag, op_count);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 0; rsp_ready = 1; junk = '0;
    req0_valid = 0; req1_valid = 0;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    m_total = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_rsp_id", 32'(rsp_id), 32'(0));
    chk("reset_rsp_y", 32'(rsp_y), 32'(0));
    chk("reset_rsp_flag", 32'(rsp_flag), 32'(0));
    started = 1;

    // Single add with carry from requester 0.
    cycle(1, 1, 3'd0, 4'd9, 4'd8, 0, 0, 0, 0, 1);
    idle(4);

    // Continuous dual requests right after reset: 0 wins first, then alternation.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) cycle(1, 1, 3'd2, 4'd15, 4'd0, 1, 3'd1, 4'd3, 4'd5, 1);
    idle(3);

    // Logic op following a carry-producing add.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1, 3'd0, 4'd15, 4'd1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1, 3'd6, 4'b1010, 4'b0110, 1);
    idle(2);

    // Backpressure: five stalled RESP cycles with both requesters waiting.
    cycle(1, 1, 3'd1, 4'd2, 4'd7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 3'd3, 4'd0, 4'd0, 1, 3'd5, 4'd4, 4'd9, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Reset while the accepted operation is in EXEC discards it.
    cycle(1, 1, 3'd0, 4'd7, 4'd7, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);

    // Randomized traffic, long enough to saturate the optional counter.
    for (int i = 0; i < 1800; i++) rcycle(85);
    idle(4);

`ifdef ALU_SHARE_CTRL_STATS_EN
    if (m_total >= 260) chk("op_count_saturated", 32'(op_count), 32'(255));
    else chk("op_count_final", 32'(op_count), 32'(m_count));
`else
    chk("op_count_disabled", 32'(op_count), 32'(0));
`endif
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequential controller that shares the single combinational 4-bit ALU between two requesters. It arbitrates round-robin and registers the winning operation onto the ALU select and operand lines. It then captures the ALU result and returns it through a valid/ready response channel tagged with the requester ID. It sits between the requesting units and the ALU instance and is the only driver of the ALU's `s`, `a`, `b` inputs.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req0_valid`, `req1_valid`  in  1 each  requester has an operation pending
- `req0_ready`, `req1_ready`  out  1 each  controller accepts the operation this cycle
- `req0_op`, `req1_op`  in  3 each  ALU select code, 000..111
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  4 each  operands
- `alu_s`  out  3  to ALU select
- `alu_a`, `alu_b`  out  4 each  to ALU operands
- `alu_y`  in  4  ALU result
- `alu_cout`  in  4  ALU upper result bits
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued the operation
- `rsp_y`  out  4  captured result
- `rsp_flag`  out  1  carry/borrow flag
- `op_count`  out  8  completed-operation counter (see Configuration)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally from the valids and `last_grant` (1 bit).
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than `last_grant` wins.
  - Only the winner's `reqN_ready` is 1. Both readies are 0 in EXEC and RESP.
  - On handshake, latch op/a/b and the ID into the issue registers, set `last_grant` = winner, and go to EXEC.
- EXEC (exactly one cycle):
  - `alu_s`/`alu_a`/`alu_b` are driven from the issue registers.
  - At the end of the cycle, capture `rsp_y` = `alu_y`.
  - For op 000..011, capture `rsp_flag` = `alu_cout[0]`: carry on add/increment, borrow on subtract/decrement.
  - For op 100..111, force `rsp_flag` = 0, because the ALU does not update `cout` for logic ops.
  - Go to RESP.
- RESP:
  - `rsp_valid` = 1. Response fields are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- The ALU lines hold their last issued values outside EXEC. The ALU result is sampled only in EXEC.
- Requests are never reordered or dropped once accepted. A requester dropping valid before its handshake is legal, and no operation is issued for it.

## Timing
- Reset (synchronous, `rst_n` = 0 at a rising edge):
  - state = IDLE, `last_grant` = 1 (so requester 0 wins the first tie).
  - `rsp_valid`, `rsp_id`, `rsp_y`, `rsp_flag` = 0.
  - `alu_s`/`alu_a`/`alu_b` = 0, `op_count` = 0.
  - Reset has priority over every other event.
- Reset during EXEC or RESP discards the in-flight operation. No response is produced and `op_count` does not increment.
- Latency:
  - Handshake at edge N.
  - EXEC in cycle N+1.
  - `rsp_valid` = 1 from cycle N+2.
  - Minimum 3 cycles per operation: next acceptance is possible in the cycle after response handshake.
- Throughput with `rsp_ready` held at 1: one operation per 3 cycles. Alternation holds under continuous dual requests: 0, 1, 0, 1...
- Backpressure: `rsp_ready` = 0 stalls in RESP indefinitely. Both req_ready stay 0.
- Arithmetic wrap follows the ALU: 4-bit result modulo 16. `rsp_flag` reports bit 4 only.

## Configuration
- `ALU_SHARE_CTRL_STATS_EN` defined:
  - `op_count` increments by 1 on every response handshake and saturates at 255.
  - Cleared only by reset.
- Not defined: `op_count` is tied to 0 and no counter flops are built.

## Test plan
- Reset, then only req0: op=000, a=9, b=8 → `req0_ready` at handshake, `alu_s`=000/`alu_a`=9/`alu_b`=8 in EXEC, then `rsp_valid` 2 cycles after handshake with `rsp_id`=0, `rsp_y`=1, `rsp_flag`=1.
- Both valid continuously after reset:
  - req0 op=010, a=15.
  - req1 op=001, a=3, b=5.
  - `rsp_ready`=1.
  - Required: order 0, 1, 0, 1. Responses alternate `rsp_y`=0/flag=1 and `rsp_y`=14/flag=1, one response every 3 cycles.
- Logic op after an add that produced a carry: req1 op=110, a=1010, b=0110 → `rsp_y`=1100, `rsp_flag`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_y`/`rsp_id` stable, both req_ready 0. The response completes on the cycle `rsp_ready` rises.
- Reset asserted in EXEC → next cycle IDLE, `rsp_valid`=0, no response for that op, `op_count` unchanged (0).
- With `ALU_SHARE_CTRL_STATS_EN`: 260 completed operations → `op_count`=255. Without the macro → `op_count`=0 throughout.
